// File: rtl/game_select_debouncer_if.sv
// Bundles the button-side inputs and the conditioned outputs of the
// game-select debouncer.
//
// Handshake: there is no valid/ready pair. 'count' is a one-cycle strobe
// that the consumer must take in the cycle it is high; it is never held or
// replayed. 'btn_level', 'busy' and 'dbg_state' are plain levels, valid
// every cycle.
interface game_select_debouncer_if;
  logic       btn_in;
  logic       enable;
  logic       count;
  logic       btn_level;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    output btn_in,
    output enable,
    input  count,
    input  btn_level,
    input  busy,
    input  dbg_state
  );

  modport slave (
    input  btn_in,
    input  enable,
    output count,
    output btn_level,
    output busy,
    output dbg_state
  );
endinterface

// File: rtl/game_select_debouncer.sv
// Game-select pushbutton conditioner: 2-FF synchronizer, stability-checking
// debounce FSM and a post-pulse cooldown lockout. One press yields at most
// one single-cycle 'count' pulse, and none while the cooldown is running.
module game_select_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COOLDOWN_CYCLES = 2500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  game_select_debouncer_if.slave       bus
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ?
                           DEBOUNCE_CYCLES : COOLDOWN_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES);
  // Pin level that means "not pressed"; the synchronizer resets to it.
  localparam logic REL_LEVEL = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  logic [CW-1:0] r_deb;
  logic [CW-1:0] r_cool;
  logic          r_count;
  logic          r_busy;

  logic          w_p;
  logic          w_fire;
  logic [CW-1:0] w_cool_next;

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= REL_LEVEL;
      r_s2 <= REL_LEVEL;
    end else begin
      r_s1 <= bus.btn_in;
      r_s2 <= r_s1;
    end
  end

  // Normalised press level: 1 = pressed regardless of pin polarity.
  assign w_p = BTN_ACTIVE_LOW ? ~r_s2 : r_s2;

  // Fire only on a confirmed press, with pulses enabled and no lockout active;
  // otherwise the press is dropped for good.
  always_comb begin
    w_fire = 1'b0;
    if ((r_state == S_PRESS_CHK) && w_p && (r_deb == DEB_MAX) &&
        bus.enable && (r_cool == '0)) begin
      w_fire = 1'b1;
    end
  end

  // Cooldown next value: load on fire (only possible when already zero),
  // else count down and saturate at zero.
  always_comb begin
    w_cool_next = r_cool;
    if (w_fire) begin
      w_cool_next = COOL_LOAD;
    end else if (r_cool != '0) begin
      w_cool_next = r_cool - 1'b1;
    end
  end

  // Debounce FSM with registered pulse/busy outputs and cooldown counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_deb   <= '0;
      r_cool  <= '0;
      r_count <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_count <= w_fire;
      r_cool  <= w_cool_next;
      r_busy  <= (w_cool_next != '0);
      case (r_state)
        S_IDLE: begin
          if (w_p) begin
            r_state <= S_PRESS_CHK;
            r_deb   <= CW'(1);
          end
        end
        S_PRESS_CHK: begin
          if (!w_p) begin
            r_state <= S_IDLE;
            r_deb   <= '0;
          end else if (r_deb == DEB_MAX) begin
            r_state <= S_HELD;
            r_deb   <= '0;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
        end
        S_HELD: begin
          if (!w_p) begin
            r_state <= S_REL_CHK;
            r_deb   <= CW'(1);
          end
        end
        S_REL_CHK: begin
          if (w_p) begin
            r_state <= S_HELD;
            r_deb   <= '0;
          end else if (r_deb == DEB_MAX) begin
            r_state <= S_IDLE;
            r_deb   <= '0;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_deb   <= '0;
        end
      endcase
    end
  end

  assign bus.count     = r_count;
  assign bus.busy      = r_busy;
  assign bus.btn_level = (r_state == S_HELD) || (r_state == S_REL_CHK);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_game_select_debouncer.sv
// Bench for game_select_debouncer. Two instances: dut_a (debounce 4,
// cooldown 10, active-low pin) and dut_b (debounce 4, no cooldown,
// active-high pin). Expected pulse cycles are pushed when a press is driven;
// a monitor per instance pops and compares whenever 'count' is high.
module tb_game_select_debouncer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_select_debouncer_if bus_a ();
  game_select_debouncer_if bus_b ();

  game_select_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(10),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  game_select_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(0),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every 'count' pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (bus_a.count === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pulse_a: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        chk("pulse_a_cycle", cyc, exp_q_a.pop_front());
      end
    end
    if (bus_b.count === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pulse_b: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        chk("pulse_b_cycle", cyc, exp_q_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driving happens just after a negedge; a value driven while cyc==c is
  // first sampled at edge c+1, so a clean press yields a pulse seen at c+7.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_a(input bit pressed);
    bus_a.btn_in = pressed ? 1'b0 : 1'b1;
  endtask

  task automatic press_a(input int hold, input int rel, input bit exp_fire);
    if (exp_fire) exp_q_a.push_back(cyc + 7);
    set_a(1'b1);
    tick(hold);
    set_a(1'b0);
    tick(rel);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] pat;
    rst           = 1'b1;
    bus_a.btn_in  = 1'b1;
    bus_a.enable  = 1'b1;
    bus_b.btn_in  = 1'b0;
    bus_b.enable  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk("rst_count_a", {31'd0, bus_a.count}, 0);
    chk("rst_level_a", {31'd0, bus_a.btn_level}, 0);
    chk("rst_busy_a",  {31'd0, bus_a.busy}, 0);
    chk("rst_state_a", {30'd0, bus_a.dbg_state}, 0);
    chk("rst_count_b", {31'd0, bus_b.count}, 0);
    chk("rst_level_b", {31'd0, bus_b.btn_level}, 0);
    chk("rst_busy_b",  {31'd0, bus_b.busy}, 0);
    chk("rst_state_b", {30'd0, bus_b.dbg_state}, 0);
    tick(2);

    // T1: clean press held 20 cycles, one pulse, level rises with it
    exp_q_a.push_back(cyc + 7);
    set_a(1'b1);
    tick(6);
    chk("t1_level_before", {31'd0, bus_a.btn_level}, 0);
    tick(1);
    chk("t1_level_at_pulse", {31'd0, bus_a.btn_level}, 1);
    tick(13);
    set_a(1'b0);
    tick(20);
    chk("t1_level_released", {31'd0, bus_a.btn_level}, 0);

    // T2: bounce 1,0,1,1,0,1 then steady pressed
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      if (i == 0) exp_q_a.push_back(cyc + 7);
      set_a(pat[i]);
      tick(1);
    end
    tick(14);
    set_a(1'b0);
    tick(20);

    // T3: first press fires, second swallowed by cooldown, third fires
    press_a(5, 5, 1'b1);
    chk("t3_busy_mid", {31'd0, bus_a.busy}, 1);
    press_a(8, 8, 1'b0);
    chk("t3_busy_done", {31'd0, bus_a.busy}, 0);
    tick(4);
    press_a(10, 12, 1'b1);
    tick(8);

    // T4: enable low across the fire cycle drops the press
    bus_a.enable = 1'b0;
    set_a(1'b1);
    tick(8);
    chk("t4_level_held", {31'd0, bus_a.btn_level}, 1);
    chk("t4_busy_idle",  {31'd0, bus_a.busy}, 0);
    bus_a.enable = 1'b1;
    tick(4);
    set_a(1'b0);
    tick(12);
    press_a(10, 20, 1'b1);

    // T5a: reset mid press check, button held -> full re-debounce
    set_a(1'b1);
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("t5a_count", {31'd0, bus_a.count}, 0);
    chk("t5a_level", {31'd0, bus_a.btn_level}, 0);
    chk("t5a_state", {30'd0, bus_a.dbg_state}, 0);
    rst = 1'b0;
    exp_q_a.push_back(cyc + 7);
    tick(12);
    set_a(1'b0);
    tick(20);

    // T5b: reset mid cooldown, button held -> cooldown cleared, fires again
    exp_q_a.push_back(cyc + 7);
    set_a(1'b1);
    tick(9);
    chk("t5b_busy_before", {31'd0, bus_a.busy}, 1);
    rst = 1'b1;
    tick(1);
    chk("t5b_busy",  {31'd0, bus_a.busy}, 0);
    chk("t5b_level", {31'd0, bus_a.btn_level}, 0);
    rst = 1'b0;
    exp_q_a.push_back(cyc + 7);
    tick(12);
    set_a(1'b0);
    tick(20);

    // T6: active-high pin polarity, same timing, no cooldown
    exp_q_b.push_back(cyc + 7);
    bus_b.btn_in = 1'b1;
    tick(6);
    chk("t6_level_before", {31'd0, bus_b.btn_level}, 0);
    tick(1);
    chk("t6_level_at_pulse", {31'd0, bus_b.btn_level}, 1);
    chk("t6_busy", {31'd0, bus_b.busy}, 0);
    tick(13);
    bus_b.btn_in = 1'b0;
    tick(20);

    // Every expected pulse must have been seen
    chk("drain_a", exp_q_a.size(), 0);
    chk("drain_b", exp_q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
